// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants and FSM state type for the elevator call path
package elevator_pkg;

  localparam int FLOORS_DEFAULT = 5;
  localparam int FLOOR_W        = $clog2(FLOORS_DEFAULT);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } call_fsm_e;

endpackage

// File: rtl/elevator_call_panel_button_debounce.sv
// rtl/elevator_call_panel_button_debounce.sv - 2-flop synchronizer plus debounce counter for one button
module button_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the differing sample that arrives once the run has
  // already reached DEBOUNCE_CYCLES, so a raw rise at edge 0 shows at edge 2+N.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - call latching, lamps and round-robin request issue to the controller
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int FLOORS          = FLOORS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FLOORS-1:0]            btn,
  output logic                         req_valid,
  output logic [FLOORS-1:0]            req_floor,
  input  logic                         req_ready,
  input  logic                         served_valid,
  input  logic [$clog2(FLOORS)-1:0]    served_floor,
  output logic [FLOORS-1:0]            lamp,
  output logic [$clog2(FLOORS+1)-1:0]  pending_count
);

  localparam int FW = $clog2(FLOORS);
  localparam int CW = $clog2(FLOORS + 1);
  localparam logic [FLOORS-1:0] ONE_HOT_BASE = FLOORS'(1);

  logic [FLOORS-1:0] level_vec, rise_vec;

  for (genvar f = 0; f < FLOORS; f++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn[f]),
      .level  (level_vec[f]),
      .rise   (rise_vec[f])
    );
  end

  function automatic logic [FW-1:0] rr_pick(input logic [FLOORS-1:0] vec,
                                            input logic [FW-1:0]     start);
    logic [FW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      idx = int'(start) + i;
      if (idx >= FLOORS) idx = idx - FLOORS;
      if (!found && vec[idx[FW-1:0]]) begin
        pick  = idx[FW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  call_fsm_e         state_q;
  logic [FLOORS-1:0] lamp_q, lamp_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [CW-1:0]     count_q, count_d;
  logic [FW-1:0]     ptr_q, sel_q;
  logic              req_valid_q;
  logic [FLOORS-1:0] req_floor_q;

  logic              hs;
  logic [FLOORS-1:0] served_mask, hs_mask, call_evt, avail, next_onehot;
  logic [FW-1:0]     next_ptr, next_sel;

  always_comb begin
    served_mask = '0;
    if (served_valid && (int'(served_floor) < FLOORS)) served_mask[served_floor] = 1'b1;

    hs       = (state_q == SEND) && req_ready;
    hs_mask  = hs ? req_floor_q : '0;
    call_evt = rise_vec & level_vec & ~lamp_q;

    // Served beats a same-cycle call because the mask is applied last.
    lamp_d    = (lamp_q | call_evt) & ~served_mask;
    pending_d = (pending_q | call_evt) & ~served_mask & ~hs_mask;

    avail       = pending_q & ~served_mask & ~hs_mask;
    next_ptr    = hs ? ((sel_q == FW'(FLOORS - 1)) ? '0 : sel_q + 1'b1) : ptr_q;
    next_sel    = rr_pick(avail, next_ptr);
    next_onehot = ONE_HOT_BASE << next_sel;

    count_d = '0;
    for (int i = 0; i < FLOORS; i++) count_d = count_d + CW'(lamp_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lamp_q      <= '0;
      pending_q   <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      sel_q       <= '0;
      req_valid_q <= 1'b0;
      req_floor_q <= '0;
    end else begin
      lamp_q    <= lamp_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      case (state_q)
        IDLE: begin
          if (|avail) begin
            state_q     <= SEND;
            sel_q       <= next_sel;
            req_valid_q <= 1'b1;
            req_floor_q <= next_onehot;
          end
        end
        SEND: begin
          if (hs) begin
            ptr_q <= next_ptr;
            if (|avail) begin
              sel_q       <= next_sel;
              req_floor_q <= next_onehot;
            end else begin
              state_q     <= IDLE;
              req_valid_q <= 1'b0;
              req_floor_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_valid     = req_valid_q;
  assign req_floor     = req_floor_q;
  assign lamp          = lamp_q;
  assign pending_count = count_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - scoreboard bench for elevator_call_panel
module tb_elevator_call_panel;

  localparam int F  = 5;
  localparam int DC = 4;
  localparam int FW = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [F-1:0]  btn = '0;
  logic          req_ready = 1'b0;
  logic          served_valid = 1'b0;
  logic [FW-1:0] served_floor = '0;
  logic          req_valid;
  logic [F-1:0]  req_floor;
  logic [F-1:0]  lamp;
  logic [CW-1:0] pending_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  elevator_call_panel #(.FLOORS(F), .DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .req_ready    (req_ready),
    .served_valid (served_valid),
    .served_floor (served_floor),
    .lamp         (lamp),
    .pending_count(pending_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-floor sample history, call set, and one outstanding request.
  int          m_s1[F], m_s2[F], m_lvl[F], m_run[F], m_rise[F];
  bit [F-1:0]  m_lamp, m_pend;
  int          m_cur = -1;
  int          m_ptr = 0;
  int          exp_q[$];
  bit [F-1:0]  s_m, calls_m, hs_m, avail_m;

  function automatic int rr(input bit [F-1:0] v, input int start);
    for (int i = 0; i < F; i++)
      if (v[(start + i) % F]) return (start + i) % F;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < F; f++) begin
        m_s1[f] = 0; m_s2[f] = 0; m_lvl[f] = 0; m_run[f] = 0; m_rise[f] = 0;
      end
      m_lamp = '0; m_pend = '0; m_cur = -1; m_ptr = 0;
      exp_q.delete();
    end else begin
      s_m = '0;
      if (served_valid && served_floor < F) s_m[served_floor] = 1'b1;
      calls_m = '0;
      for (int f = 0; f < F; f++) if (m_rise[f] != 0 && !m_lamp[f]) calls_m[f] = 1'b1;
      hs_m = '0;
      if (m_cur >= 0 && req_ready) hs_m[m_cur] = 1'b1;
      avail_m = m_pend & ~s_m & ~hs_m;
      if (m_cur < 0) begin
        m_cur = rr(avail_m, m_ptr);
        if (m_cur >= 0) exp_q.push_back(m_cur);
      end else if (req_ready) begin
        m_ptr = (m_cur + 1) % F;
        m_cur = rr(avail_m, m_ptr);
        if (m_cur >= 0) exp_q.push_back(m_cur);
      end
      m_pend = (m_pend | calls_m) & ~s_m & ~hs_m;
      m_lamp = (m_lamp | calls_m) & ~s_m;
      for (int f = 0; f < F; f++) begin
        m_rise[f] = 0;
        if (m_s2[f] != m_lvl[f]) begin
          if (m_run[f] >= DC) begin
            m_lvl[f] = m_s2[f]; m_rise[f] = m_s2[f]; m_run[f] = 0;
          end else m_run[f]++;
        end else m_run[f] = 0;
        m_s2[f] = m_s1[f];
        m_s1[f] = int'(btn[f]);
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and tracks visible state.
  int         hs_total = 0;
  int         hs_log[$];
  int         hs_cycle[$];
  int         cyc = 0;
  bit         prev_stall = 0;
  logic [F-1:0] prev_floor = '0;
  int         e;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("lamp", int'(lamp), int'(m_lamp));
      chk("pending_count", int'(pending_count), $countones(m_lamp));
      chk("req_valid", int'(req_valid), int'(m_cur >= 0));
      if (prev_stall) chk("req_floor_stable", int'(req_floor), int'(prev_floor));
      if (req_valid && req_ready) begin
        hs_total++;
        hs_log.push_back(int'(req_floor));
        hs_cycle.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_request: got floor %b, expected none", req_floor);
        end else begin
          e = exp_q.pop_front();
          chk("req_floor", int'(req_floor), 1 << e);
        end
      end
      prev_stall = req_valid && !req_ready;
      prev_floor = req_floor;
    end else begin
      prev_stall = 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn = '0; req_ready = 1'b0; served_valid = 1'b0; served_floor = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  int hs0, log0;

  initial begin
    // 1: reset values and glitch rejection
    do_reset();
    chk("rst_lamp", int'(lamp), 0);
    chk("rst_req_valid", int'(req_valid), 0);
    chk("rst_req_floor", int'(req_floor), 0);
    chk("rst_pending_count", int'(pending_count), 0);
    hs0 = hs_total;
    btn[2] = 1'b1;
    repeat (3) tick();
    btn[2] = 1'b0;
    repeat (15) tick();
    chk("glitch_lamp", int'(lamp), 0);
    chk("glitch_requests", hs_total - hs0, 0);

    // 2: single call, latency and stall
    do_reset();
    hs0 = hs_total;
    btn[1] = 1'b1;
    tick();
    repeat (6) tick();
    chk("t2_lamp_edge6", int'(lamp), 0);
    tick();
    chk("t2_lamp_edge7", int'(lamp), 5'b00010);
    chk("t2_valid_edge7", int'(req_valid), 0);
    tick();
    chk("t2_valid_edge8", int'(req_valid), 1);
    chk("t2_floor_edge8", int'(req_floor), 5'b00010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_valid", int'(req_valid), 1);
      chk("t2_stall_floor", int'(req_floor), 5'b00010);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    repeat (10) tick();
    chk("t2_handshakes", hs_total - hs0, 1);
    btn = '0;

    // 3: round robin, back-to-back
    do_reset();
    req_ready = 1'b1;
    log0 = hs_log.size();
    btn = 5'b11001;
    repeat (8) tick();
    chk("t3_pending_count", int'(pending_count), 3);
    repeat (6) tick();
    chk("t3_handshakes", hs_log.size() - log0, 3);
    if (hs_log.size() - log0 >= 3) begin
      chk("t3_first", hs_log[log0], 5'b00001);
      chk("t3_second", hs_log[log0 + 1], 5'b01000);
      chk("t3_third", hs_log[log0 + 2], 5'b10000);
      chk("t3_gap12", hs_cycle[log0 + 1] - hs_cycle[log0], 1);
      chk("t3_gap23", hs_cycle[log0 + 2] - hs_cycle[log0 + 1], 1);
    end
    btn = '0;

    // 4: serve, then serve colliding with a call event
    do_reset();
    req_ready = 1'b1;
    btn[3] = 1'b1;
    repeat (8) tick();
    chk("t4_lamp_set", int'(lamp), 5'b01000);
    btn = '0;
    repeat (3) tick();
    served_valid = 1'b1; served_floor = 3'd3;
    tick();
    served_valid = 1'b0;
    chk("t4_lamp_clear", int'(lamp), 0);
    chk("t4_count_clear", int'(pending_count), 0);
    repeat (10) tick();
    hs0 = hs_total;
    btn[2] = 1'b1;
    tick();
    repeat (6) tick();
    served_valid = 1'b1; served_floor = 3'd2;
    tick();
    served_valid = 1'b0;
    chk("t4_conflict_lamp", int'(lamp), 0);
    repeat (5) tick();
    chk("t4_conflict_lamp_later", int'(lamp), 0);
    chk("t4_conflict_requests", hs_total - hs0, 0);
    btn = '0;

    // 5: duplicate press and out-of-range served report
    do_reset();
    req_ready = 1'b1;
    hs0 = hs_total;
    btn[4] = 1'b1;
    repeat (10) tick();
    btn[4] = 1'b0;
    repeat (10) tick();
    btn[4] = 1'b1;
    repeat (10) tick();
    chk("t5_lamp", int'(lamp), 5'b10000);
    chk("t5_requests", hs_total - hs0, 1);
    served_valid = 1'b1; served_floor = 3'd6;
    tick();
    served_valid = 1'b0;
    tick();
    chk("t5_oor_lamp", int'(lamp), 5'b10000);
    chk("t5_oor_count", int'(pending_count), 1);
    btn = '0;

    // 6: asynchronous reset while a request is held
    do_reset();
    btn = 5'b00110;
    for (int i = 0; i < 30 && !req_valid; i++) tick();
    chk("t6_valid_before", int'(req_valid), 1);
    chk("t6_lamp_before", int'(lamp), 5'b00110);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(req_valid), 0);
    chk("t6_async_lamp", int'(lamp), 0);
    chk("t6_async_count", int'(pending_count), 0);
    btn = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int f = 0; f < F; f++)
        if ($urandom_range(9, 0) == 0) btn[f] = ~btn[f];
      req_ready    = ($urandom_range(2, 0) != 0);
      served_valid = ($urandom_range(7, 0) == 0);
      served_floor = FW'($urandom_range(7, 0));
      tick();
    end
    btn = '0; served_valid = 1'b0; req_ready = 1'b1;
    repeat (20) tick();
    chk("drain_scoreboard", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/elevator_call_panel.md
# elevator_call_panel

- Request-side block for the elevator controller: it debounces the raw floor call buttons, latches calls, and drives the call lamps.
- It issues latched calls one at a time to the controller over a valid/ready handshake.
- It clears a lamp when the controller reports that floor as served.
- It sits between the panel I/O pins and the controller's floor-request input.

## Interface

Parameters:
- FLOORS, 5: number of floors/buttons.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a level change (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset; one clock domain only.
- btn  in  FLOORS  raw, asynchronous, active-high call buttons.
- req_valid  out  1  a call request is presented.
- req_floor  out  FLOORS  one-hot requested floor; valid while req_valid=1.
- req_ready  in  1  controller accepts the request.
- served_valid  in  1  controller reports a floor served this cycle.
- served_floor  in  $clog2(FLOORS)  index of the served floor.
- lamp  out  FLOORS  call lamp per floor (registered).
- pending_count  out  $clog2(FLOORS+1)  popcount of lamp.

## Operation

Reset values:
- All outputs 0.
- Synchronizers and debounced levels 0.
- FSM in IDLE.
- Round-robin pointer 0.
- pending vector 0.

Input conditioning, per floor:
- 2-flop synchronizer, then a debounce counter.
- The debounced level toggles after DEBOUNCE_CYCLES consecutive samples that differ from it.
- Any sample equal to the current debounced level resets the counter.

Call event (rising edge of the debounced level for floor f):
- If lamp[f]=0: set lamp[f] and pending[f].
- If lamp[f]=1: ignored; no duplicate request.
- Falling edges have no effect.

Served report (served_valid=1, served_floor=f):
- f<FLOORS: clear lamp[f] and pending[f] next edge.
- f≥FLOORS: ignored.
- Served wins over a same-cycle call event on the same floor; the lamp stays 0.

Transmit FSM, states IDLE and SEND:
- IDLE: if pending≠0, select the first set bit at or after the round-robin pointer (wrapping), load req_floor, assert req_valid, go to SEND.
- SEND: hold req_valid and req_floor stable until req_ready=1.
- On the handshake edge:
  - clear that pending bit;
  - set the pointer to selected+1, wrapping modulo FLOORS;
  - if other pending bits remain, load the next request on the same edge and stay in SEND (back-to-back, one request per cycle);
  - otherwise go to IDLE.
- A served report for the floor currently in SEND clears its lamp but does not withdraw req_valid; the request completes normally.
- Once in SEND, req_valid never deasserts before the handshake.

Reset asserted mid-operation immediately zeroes every output; calls in flight are lost.

## Timing

- Button rise sampled at edge 0: debounced high at edge 2+DEBOUNCE_CYCLES, lamp high at edge 3+DEBOUNCE_CYCLES. With the default, lamp rises at edge 7.
- req_valid rises 1 edge after lamp when the FSM is IDLE (edge 8 with the default).
- Served report to lamp clear: 1 edge.
- pending_count is registered and updates on the same edge as lamp.
- req_ready is ignored while req_valid=0.

## Structure

Shared package elevator_pkg holds:
- FLOORS default;
- FLOOR_W = $clog2(FLOORS);
- the FSM state enum {IDLE, SEND}, also reused by the controller.

Sub-module button_debounce:
- one instance per floor via generate;
- contains the synchronizer and debounce counter;
- outputs the debounced level and a one-cycle rise pulse.

Top level holds lamp/pending registers, round-robin arbiter, FSM and popcount.

## Test plan

1. Reset and glitch rejection:
   - Stimulus: hold rst_n=0, then release; pulse btn[2] high for 3 cycles.
   - Required: all outputs 0; lamp stays 0 and no request is issued.
2. Single call, slow ready:
   - Stimulus: btn[1] held high; keep req_ready=0 for 5 cycles, then 1.
   - Required: lamp=00010 at edge 7; req_valid=1 with req_floor=00010 at edge 8, stable through the stall; exactly one handshake.
3. Round-robin with back-to-back acceptance:
   - Stimulus: btn[0], btn[3] and btn[4] rise together; req_ready=1 constantly.
   - Required: requests 00001, 01000, 10000 on consecutive cycles; pending_count=3.
4. Serve and same-cycle conflict:
   - Stimulus: served_valid=1, served_floor=3 with lamp=01000; separately, a served report for floor 2 on the same cycle as a call event for floor 2.
   - Required: lamp→00000 next edge, pending_count→0; in the conflict case lamp[2] stays 0.
5. Duplicate and out-of-range:
   - Stimulus: btn[4] pressed twice while lamp[4]=1; served_floor=6 reported.
   - Required: one request only; no lamp change.
6. Reset mid-SEND:
   - Stimulus: drive rst_n low while req_valid=1.
   - Required: req_valid, lamp and pending_count are 0 without waiting for a clock edge.
